// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
// AHB-Lite slave backed by a register-array memory. Each accepted beat runs an
// independent data phase. OKAY beats insert WAIT_STATES wait cycles. Illegal
// beats get the two-cycle ERROR response and never touch memory.
//
// Ports:
//   HCLK, HRESETn      clock, async active-low reset
//   HSEL, HADDR,       address-phase inputs, sampled when
//   HTRANS, HWRITE,    HSEL & HREADY & HTRANS[1]
//   HSIZE, HBURST      (HBURST is unused: beats are handled independently)
//   HREADY             bus-wide ready
//   HWDATA             write data, data phase
//   HRDATA             read data (full word, zero outside a read data phase)
//   HREADYOUT, HRESP   slave ready / error response
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no data phase pending
// ST_WAIT | wait-state counter running (HREADYOUT low)
// ST_DATA | final data-phase cycle; writes commit on its end
// ST_ERR1 | first ERROR cycle (HREADYOUT low, HRESP high)
// ST_ERR2 | second ERROR cycle (HREADYOUT high, HRESP high)
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic                  ready_q;
  logic                  resp_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic       accept;
  logic       illegal;
  logic [3:0] lane_en;
  logic       unused_in;

  assign unused_in = ^{HBURST, HTRANS[0]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = (HSIZE > 3'd2)
                || ((HSIZE == 3'd1) && HADDR[0])
                || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all drive HREADYOUT high, so a new beat may land here
          if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            if (illegal) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state   <= ST_WAIT;
              cnt     <= WS_LOAD;
              ready_q <= 1'b0;
              resp_q  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              ready_q <= 1'b1;
              resp_q  <= 1'b0;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Little-endian lane enables from the registered size and low address bits
  always_comb begin
    lane_en = 4'b1111;
    case (size_q)
      3'd0:    lane_en = 4'b0001 << addr_q[1:0];
      3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Memory has no reset; only the last data-phase cycle of a write commits
  always_ff @(posedge HCLK) begin
    if ((state == ST_DATA) && write_q) begin
      for (int n = 0; n < 4; n++) begin
        if (lane_en[n]) begin
          mem[addr_q[ADDR_WIDTH-1:2]][8*n +: 8] <= HWDATA[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (((state == ST_WAIT) || (state == ST_DATA)) && !write_q) begin
      HRDATA = mem[addr_q[ADDR_WIDTH-1:2]];
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel3;
  logic [9:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, resp0, resp3;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(ready0), .HWDATA(HWDATA),
    .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(ready3), .HWDATA(HWDATA),
    .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                              logic [9:0] addr, logic [31:0] wdata,
                              logic e_rdy, logic e_resp, logic [31:0] e_rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One transfer on the WAIT_STATES=3 instance; starts and ends just after a rising edge
  task automatic xfer3(input logic wr, input logic [9:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output int lows,
                       output logic [31:0] rd, output logic rsp);
    bit done;
    hsel3 = 1'b1; HTRANS = 2'd2; HWRITE = wr; HADDR = addr; HSIZE = size;
    @(posedge HCLK); #1;
    HTRANS = 2'd0; hsel3 = 1'b0; HWDATA = wdata;
    lows = 0; rd = '0; rsp = 1'b0; done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge HCLK);
      if (ready3) begin
        done = 1; rd = rdata3; rsp = resp3;
      end else begin
        lows++;
      end
      @(posedge HCLK); #1;
    end
    if (!done) chk("xfer3_timeout", 32'd0, 32'd1);
  endtask

  int          lows, cyc;
  logic [31:0] rd;
  logic        rsp;
  bit          done;
  logic [31:0] bdata[4];

  initial begin
    HRESETn = 1'b0; hsel0 = 0; hsel3 = 0; HADDR = '0; HTRANS = 2'd0;
    HWRITE = 0; HSIZE = 3'd0; HBURST = 3'd0; HWDATA = '0;

    //           sel trans wr size addr   wdata          rdy resp rdata
    vecs[0]  = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'h0);
    vecs[1]  = mk(1, 2'd2, 1, 3'd2, 10'h10, 32'h0,        1, 0, 32'h0);
    vecs[2]  = mk(1, 2'd2, 0, 3'd2, 10'h10, 32'hDEADBEEF, 1, 0, 32'h0);
    vecs[3]  = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'hDEADBEEF);
    vecs[4]  = mk(1, 2'd2, 1, 3'd2, 10'h20, 32'h0,        1, 0, 32'h0);
    vecs[5]  = mk(1, 2'd2, 1, 3'd0, 10'h21, 32'h11223344, 1, 0, 32'h0);
    vecs[6]  = mk(1, 2'd2, 1, 3'd1, 10'h22, 32'h0000AA00, 1, 0, 32'h0);
    vecs[7]  = mk(1, 2'd2, 0, 3'd2, 10'h20, 32'hBBCC0000, 1, 0, 32'h0);
    vecs[8]  = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'hBBCCAA44);
    vecs[9]  = mk(1, 2'd2, 1, 3'd2, 10'h12, 32'h0,        1, 0, 32'h0);
    vecs[10] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'hFFFFFFFF, 0, 1, 32'h0);
    vecs[11] = mk(1, 2'd2, 0, 3'd2, 10'h10, 32'hFFFFFFFF, 1, 1, 32'h0);
    vecs[12] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'hDEADBEEF);
    vecs[13] = mk(1, 2'd2, 1, 3'd3, 10'h20, 32'h0,        1, 0, 32'h0);
    vecs[14] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'hFFFFFFFF, 0, 1, 32'h0);
    vecs[15] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'hFFFFFFFF, 1, 1, 32'h0);
    vecs[16] = mk(1, 2'd2, 1, 3'd1, 10'h21, 32'h0,        1, 0, 32'h0);
    vecs[17] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'hFFFFFFFF, 0, 1, 32'h0);
    vecs[18] = mk(1, 2'd2, 0, 3'd2, 10'h20, 32'hFFFFFFFF, 1, 1, 32'h0);
    vecs[19] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'hBBCCAA44);
    vecs[20] = mk(1, 2'd1, 1, 3'd2, 10'h20, 32'h0,        1, 0, 32'h0);
    vecs[21] = mk(0, 2'd2, 1, 3'd2, 10'h20, 32'hFFFFFFFF, 1, 0, 32'h0);
    vecs[22] = mk(1, 2'd2, 0, 3'd2, 10'h20, 32'hFFFFFFFF, 1, 0, 32'h0);
    vecs[23] = mk(0, 2'd0, 0, 3'd0, 10'h00, 32'h0,        1, 0, 32'hBBCCAA44);

    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_resp0",  32'(resp0),  32'd0);
    chk("rst_rdata0", rdata0,      32'd0);
    chk("rst_ready3", 32'(ready3), 32'd1);
    HRESETn = 1'b1;

    // Pipelined table on the zero-wait instance: each row is one clock cycle
    for (int i = 0; i < 24; i++) begin
      hsel0 = vecs[i].sel; HTRANS = vecs[i].trans; HWRITE = vecs[i].wr;
      HSIZE = vecs[i].size; HADDR = vecs[i].addr; HWDATA = vecs[i].wdata;
      @(negedge HCLK);
      chk($sformatf("v%0d_ready", i), 32'(ready0), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_resp", i),  32'(resp0),  32'(vecs[i].e_resp));
      chk($sformatf("v%0d_rdata", i), rdata0,      vecs[i].e_rdata);
      @(posedge HCLK); #1;
    end
    hsel0 = 0; HTRANS = 2'd0;

    // Wait-state instance: single write then read, 3 low cycles each
    xfer3(1'b1, 10'h10, 3'd2, 32'h12345678, lows, rd, rsp);
    chk("ws3_wr_lows", 32'(lows), 32'd3);
    chk("ws3_wr_resp", 32'(rsp),  32'd0);
    xfer3(1'b0, 10'h10, 3'd2, 32'h0, lows, rd, rsp);
    chk("ws3_rd_lows",  32'(lows), 32'd3);
    chk("ws3_rd_data",  rd,        32'h12345678);
    xfer3(1'b0, 10'h11, 3'd0, 32'h0, lows, rd, rsp);
    chk("ws3_byte_rd_data", rd, 32'h12345678);
    xfer3(1'b0, 10'h02, 3'd2, 32'h0, lows, rd, rsp);
    chk("ws3_err_lows", 32'(lows), 32'd1);
    chk("ws3_err_resp", 32'(rsp),  32'd1);

    // INCR4 burst of word writes: 4 beats x 4 data-phase cycles
    bdata[0] = 32'hA0A0A0A0; bdata[1] = 32'hB1B1B1B1;
    bdata[2] = 32'hC2C2C2C2; bdata[3] = 32'hD3D3D3D3;
    hsel3 = 1; HTRANS = 2'd2; HWRITE = 1; HSIZE = 3'd2; HBURST = 3'd3; HADDR = 10'h40;
    @(posedge HCLK); #1;
    cyc = 0;
    for (int b = 0; b < 4; b++) begin
      HWDATA = bdata[b];
      if (b < 3) begin
        HTRANS = 2'd3; HADDR = 10'(10'h40 + 4 * (b + 1));
      end else begin
        HTRANS = 2'd0; hsel3 = 0;
      end
      done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
        @(negedge HCLK);
        cyc++;
        if (ready3) done = 1;
        @(posedge HCLK); #1;
      end
      if (!done) chk("burst_timeout", 32'd0, 32'd1);
    end
    HBURST = 3'd0;
    chk("burst_cycles", 32'(cyc), 32'd16);
    xfer3(1'b0, 10'h44, 3'd2, 32'h0, lows, rd, rsp);
    chk("burst_rd_44", rd, 32'hB1B1B1B1);
    xfer3(1'b0, 10'h4C, 3'd2, 32'h0, lows, rd, rsp);
    chk("burst_rd_4c", rd, 32'hD3D3D3D3);

    // Asynchronous reset in the middle of a waited read
    hsel3 = 1; HTRANS = 2'd2; HWRITE = 0; HSIZE = 3'd2; HADDR = 10'h10;
    @(posedge HCLK); #1;
    HTRANS = 2'd0; hsel3 = 0;
    @(posedge HCLK); #2;
    chk("mid_ready", 32'(ready3), 32'd0);
    chk("mid_rdata", rdata3,      32'h12345678);
    HRESETn = 1'b0;
    #1;
    chk("arst_ready", 32'(ready3), 32'd1);
    chk("arst_resp",  32'(resp3),  32'd0);
    chk("arst_rdata", rdata3,      32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    xfer3(1'b0, 10'h10, 3'd2, 32'h0, lows, rd, rsp);
    chk("post_rst_lows", 32'(lows), 32'd3);
    chk("post_rst_data", rd,        32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Synthesizable AHB-Lite slave backed by a register-array memory. It is the device under test that the master agent drives and the slave monitor observes. It accepts single and burst transfers and inserts a configurable number of wait states per transfer. Byte, halfword and word writes use HSIZE/HADDR lane selection. Unsupported or misaligned transfers get the two-cycle AHB ERROR response.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width; memory depth = 2^(ADDR_WIDTH-2) words
- DATA_WIDTH, 32, bus width; fixed at 32
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15)

Ports:
- HCLK  in  1  clock; all state changes on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  byte address (upper master bits dropped by the decoder)
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; others illegal
- HBURST  in  3  ignored; each beat is handled independently
- HREADY  in  1  bus-wide ready (previous data phase completing)
- HWDATA  in  32  write data, valid in the data phase
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1] at a rising edge.
  - Address, HWRITE and HSIZE are registered as the data-phase control.
- IDLE or BUSY with HSEL & HREADY: no transfer, no state change.
- Illegal transfer: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- States:
  - ST_IDLE: no data phase pending. HREADYOUT=1, HRESP=0.
  - ST_WAIT: wait-state counter running. HREADYOUT=0, HRESP=0.
  - ST_DATA: final data-phase cycle. HREADYOUT=1, HRESP=0.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - From IDLE, DATA or ERR2 (HREADYOUT=1):
    - legal accept → WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or DATA (WAIT_STATES=0)
    - illegal accept → ERR1
    - otherwise → IDLE
  - WAIT: counter decrements each cycle; at 0 → DATA.
  - ERR1 → ERR2 unconditionally.
  - Transfers are not sampled in WAIT or ERR1, because HREADY is low then.
- Write commit:
  - Occurs on the edge ending ST_DATA for a write.
  - Byte lanes enabled per HSIZE and registered HADDR[1:0], little-endian. Lane n = HWDATA[8n+7:8n].
  - Other lanes are unchanged.
- Read data:
  - HRDATA = full memory word at registered address while in WAIT or DATA of a read.
  - HRDATA = 0 in all other states.
  - Masters extract lanes themselves.
- ERROR transfers never modify memory.
  - A transfer presented during ERR2 is still accepted (AHB-Lite allows it).
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset asserted (async): state=ST_IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - Any pending data phase, including an uncommitted write, is discarded.
- Deassertion is synchronized externally. The first accept is possible on the first edge with HRESETn=1.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles. HREADYOUT is high only in its last cycle.
- Back-to-back (pipelined) accepts are supported: with WAIT_STATES=0, one beat per cycle sustained.
- Read immediately after write to the same word returns the new data, because the write commits before the read's data phase.
- ERROR: exactly 2 cycles (HREADYOUT 0 then 1, HRESP=1 both cycles). WAIT_STATES does not apply.
- HSEL low at accept time (even with HTRANS active): treated as no transfer.

## Test plan
- Reset: hold HRESETn=0 mid-burst → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously, within the same cycle.
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back → read data phase returns 0xDEADBEEF, HREADYOUT never low.
- Byte/halfword lanes: word write 0x11223344 to 0x20, byte write 0xAA (lane 1) to 0x21, halfword write 0xBBCC (upper half, HWDATA[31:16]) to 0x22 → read 0x20 = 0xBBCCAA44.
- WAIT_STATES=3: NONSEQ read → HREADYOUT low exactly 3 cycles then high 1; INCR4 burst of 4 writes takes 16 data-phase cycles.
- Errors: word at 0x02 and HSIZE=3 at 0x00 → each gives HRESP=1 for 2 cycles, HREADYOUT 0 then 1, memory unchanged on readback. An OKAY transfer issued during ERR2 completes normally.
- IDLE/BUSY with HSEL=1, and NONSEQ with HSEL=0 → state stays ST_IDLE, no memory change.
